// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with binary wrap-bit pointers, occupancy count, programmable
// almost-full/almost-empty flags, sticky error flags, flush and optional FWFT read.
module sync_fifo_flex #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wpush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rpull,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_V  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_V = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  if (ADDR_WIDTH < 1) begin : g_chk_aw
    $error("sync_fifo_flex: ADDR_WIDTH must be >= 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_af
    $error("sync_fifo_flex: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_chk_ae
    $error("sync_fifo_flex: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr, rptr, cnt;
  logic                  ovf, unf;
  logic                  wen, ren;

  // Flags decode only from the registered count, never from push/pull.
  assign wfull         = (cnt == DEPTH_V);
  assign rempty        = (cnt == '0);
  assign walmost_full  = (cnt >= AFULL_V);
  assign ralmost_empty = (cnt <= AEMPTY_V);
  assign count         = cnt;
  assign overflow      = ovf;
  assign underflow     = unf;

  assign wen = wpush && !wfull  && !flush;
  assign ren = rpull && !rempty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      if (wen) wptr <= wptr + 1'b1;
      if (ren) rptr <= rptr + 1'b1;
      case ({wen, ren})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wpush && wfull)  ovf <= 1'b1;
      if (rpull && rempty) unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wen) mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    assign rdata  = mem[rptr[ADDR_WIDTH-1:0]];
    assign rvalid = !rempty;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] rdata_p1;
    logic                  vld_p1;

    // p0 -> p1: popped word registered, one cycle after the accepted pull.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_p1 <= '0;
        vld_p1   <= 1'b0;
      end else begin
        vld_p1 <= ren;
        if (ren) rdata_p1 <= mem[rptr[ADDR_WIDTH-1:0]];
      end
    end

    assign rdata  = rdata_p1;
    assign rvalid = vld_p1;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: registered-read and FWFT instances driven by the same stimulus.
module tb_sync_fifo_flex;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        wpush = 1'b0;
  logic        rpull = 1'b0;
  logic [31:0] wdata = '0;

  logic        f0, af0, rv0, re0, ae0, ov0, un0;
  logic [31:0] rd0;
  logic [4:0]  c0;
  logic        f1, af1, rv1, re1, ae1, ov1, un1;
  logic [31:0] rd1;
  logic [4:0]  c1;

  int n_chk = 0;
  int n_fail = 0;

  sync_fifo_flex #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .wpush(wpush), .wdata(wdata), .wfull(f0),
    .walmost_full(af0), .rpull(rpull), .rdata(rd0), .rvalid(rv0), .rempty(re0),
    .ralmost_empty(ae0), .count(c0), .overflow(ov0), .underflow(un0)
  );

  sync_fifo_flex #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .wpush(wpush), .wdata(wdata), .wfull(f1),
    .walmost_full(af1), .rpull(rpull), .rdata(rd1), .rvalid(rv1), .rempty(re1),
    .ralmost_empty(ae1), .count(c1), .overflow(ov1), .underflow(un1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(c0), 32'd0);
    chk("rst_rempty", 32'(re0), 32'd1);
    chk("rst_ralmost_empty", 32'(ae0), 32'd1);
    chk("rst_wfull", 32'(f0), 32'd0);
    chk("rst_walmost_full", 32'(af0), 32'd0);
    chk("rst_rvalid", 32'(rv0), 32'd0);
    chk("rst_rdata", rd0, 32'd0);
    chk("rst_overflow", 32'(ov0), 32'd0);
    chk("rst_underflow", 32'(un0), 32'd0);
    chk("rst_fwft_rvalid", 32'(rv1), 32'd0);
    rst = 1'b0;
    tick();

    // Fill 0..15
    for (int i = 0; i < 16; i++) begin
      wpush = 1'b1;
      wdata = 32'(i);
      tick();
      chk("fill_count", 32'(c0), 32'(i + 1));
      chk("fill_walmost_full", 32'(af0), 32'(i + 1 >= 12));
      chk("fill_wfull", 32'(f0), 32'(i + 1 == 16));
      chk("fill_ralmost_empty", 32'(ae0), 32'(i + 1 <= 2));
      chk("fill_rvalid", 32'(rv0), 32'd0);
      chk("fill_fwft_head", rd1, 32'd0);
      chk("fill_fwft_rvalid", 32'(rv1), 32'd1);
    end

    // Full with push+pull: read taken, write of 0x99 dropped
    wpush = 1'b1;
    wdata = 32'h99;
    rpull = 1'b1;
    tick();
    chk("full_coll_count", 32'(c0), 32'd15);
    chk("full_coll_overflow", 32'(ov0), 32'd1);
    chk("full_coll_wfull", 32'(f0), 32'd0);
    chk("full_coll_rvalid", 32'(rv0), 32'd1);
    chk("full_coll_rdata", rd0, 32'd0);
    wpush = 1'b0;

    // Drain remaining 1..15
    for (int i = 1; i < 16; i++) begin
      chk("drain_fwft_head", rd1, 32'(i));
      rpull = 1'b1;
      tick();
      chk("drain_rdata", rd0, 32'(i));
      chk("drain_rvalid", 32'(rv0), 32'd1);
      chk("drain_count", 32'(c0), 32'(15 - i));
      chk("drain_ralmost_empty", 32'(ae0), 32'(15 - i <= 2));
      chk("drain_overflow_sticky", 32'(ov0), 32'd1);
    end
    chk("drain_rempty", 32'(re0), 32'd1);

    // Empty with push+pull: write taken, read ignored
    wpush = 1'b1;
    wdata = 32'h77;
    rpull = 1'b1;
    tick();
    chk("empty_coll_count", 32'(c0), 32'd1);
    chk("empty_coll_underflow", 32'(un0), 32'd1);
    chk("empty_coll_rvalid", 32'(rv0), 32'd0);
    chk("empty_coll_rdata_hold", rd0, 32'd15);
    chk("empty_coll_fwft_rdata", rd1, 32'h77);
    chk("empty_coll_fwft_rvalid", 32'(rv1), 32'd1);
    rpull = 1'b0;

    // Bring count to 7, then flush alongside push+pull
    for (int i = 0; i < 6; i++) begin
      wdata = 32'h100 + 32'(i);
      tick();
    end
    chk("pre_flush_count", 32'(c0), 32'd7);
    flush = 1'b1;
    wpush = 1'b1;
    rpull = 1'b1;
    wdata = 32'hEE;
    tick();
    chk("flush_count", 32'(c0), 32'd0);
    chk("flush_rempty", 32'(re0), 32'd1);
    chk("flush_overflow", 32'(ov0), 32'd0);
    chk("flush_underflow", 32'(un0), 32'd0);
    chk("flush_rvalid", 32'(rv0), 32'd0);
    chk("flush_rdata_hold", rd0, 32'd15);
    chk("flush_fwft_rvalid", 32'(rv1), 32'd0);
    flush = 1'b0;
    rpull = 1'b0;
    wdata = 32'hAB;
    tick();
    chk("post_flush_count", 32'(c0), 32'd1);
    chk("post_flush_fwft_head", rd1, 32'hAB);
    wpush = 1'b0;
    rpull = 1'b1;
    tick();
    chk("post_flush_rdata", rd0, 32'hAB);
    chk("post_flush_rvalid", 32'(rv0), 32'd1);
    chk("post_flush_count0", 32'(c0), 32'd0);
    chk("post_flush_underflow", 32'(un0), 32'd0);

    // FWFT shows 0xA5 without a pull; registered read needs one
    rpull = 1'b0;
    wpush = 1'b1;
    wdata = 32'hA5;
    tick();
    wpush = 1'b0;
    chk("fwft_rdata", rd1, 32'hA5);
    chk("fwft_rvalid", 32'(rv1), 32'd1);
    chk("reg_no_pull_rvalid", 32'(rv0), 32'd0);
    rpull = 1'b1;
    tick();
    chk("reg_lat_rvalid", 32'(rv0), 32'd1);
    chk("reg_lat_rdata", rd0, 32'hA5);
    chk("reg_lat_count", 32'(c0), 32'd0);
    chk("fwft_after_pop_rvalid", 32'(rv1), 32'd0);
    rpull = 1'b0;
    tick();
    chk("reg_idle_rvalid", 32'(rv0), 32'd0);
    chk("reg_idle_rdata_hold", rd0, 32'hA5);

    // Wrap: pointers cross 2*DEPTH
    for (int r = 0; r < 3; r++) begin
      wpush = 1'b1;
      for (int k = 0; k < 10; k++) begin
        wdata = 32'(r * 256 + k);
        tick();
        chk("wrap_push_count", 32'(c0), 32'(k + 1));
      end
      wpush = 1'b0;
      chk("wrap_fwft_head", rd1, 32'(r * 256));
      rpull = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk("wrap_rdata", rd0, 32'(r * 256 + k));
        chk("wrap_pull_count", 32'(c0), 32'(9 - k));
      end
      rpull = 1'b0;
    end

    // Async reset mid-traffic
    wpush = 1'b1;
    wdata = 32'h55;
    repeat (5) tick();
    chk("pre_rst_count", 32'(c0), 32'd5);
    rpull = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(c0), 32'd0);
    chk("mid_rst_rempty", 32'(re0), 32'd1);
    chk("mid_rst_ralmost_empty", 32'(ae0), 32'd1);
    chk("mid_rst_wfull", 32'(f0), 32'd0);
    chk("mid_rst_rvalid", 32'(rv0), 32'd0);
    chk("mid_rst_overflow", 32'(ov0), 32'd0);
    chk("mid_rst_underflow", 32'(un0), 32'd0);
    tick();
    rst = 1'b0;
    rpull = 1'b0;
    wdata = 32'h3C;
    tick();
    wpush = 1'b0;
    chk("post_rst_count", 32'(c0), 32'd1);
    chk("post_rst_fwft_head", rd1, 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
